// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and default timing constants shared by the PLL lock sequencer
package pll_seq_pkg;
  localparam int PLL_SEQ_STATE_W = 3;
  typedef enum logic [PLL_SEQ_STATE_W-1:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    GATE_DLY  = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } pll_seq_state_t;
  localparam int PLL_SEQ_RST_HOLD_CYC     = 100;
  localparam int PLL_SEQ_LOCK_TIMEOUT_CYC = 50000;
  localparam int PLL_SEQ_LOCK_STABLE_CYC  = 64;
  localparam int PLL_SEQ_GATE_DELAY_CYC   = 16;
  localparam int PLL_SEQ_MAX_RETRY        = 3;
endpackage

// File: rtl/pll_seq_sync2.sv
// pll_seq_sync2: generic two-flop synchronizer with async active-low reset to 0
module pll_seq_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock-debounce/clock-gate sequencer; PLL_LOCK_LOSS_RECOVER_EN enables lock-loss auto-recovery and lost_cnt
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC     = PLL_SEQ_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = PLL_SEQ_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = PLL_SEQ_LOCK_STABLE_CYC,
  parameter int GATE_DELAY_CYC   = PLL_SEQ_GATE_DELAY_CYC,
  parameter int MAX_RETRY        = PLL_SEQ_MAX_RETRY,
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       restart,
  input  logic                       pll_lock,
  output logic                       pll_rst,
  output logic                       clkout0_gate,
  output logic                       ready,
  output logic                       fail,
  output logic [RW-1:0]              retry_cnt,
  output logic [PLL_SEQ_STATE_W-1:0] state_o
`ifdef PLL_LOCK_LOSS_RECOVER_EN
  ,
  output logic [7:0]                 lost_cnt
`endif
);
  localparam int HW = $clog2(RST_HOLD_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int GW = $clog2(GATE_DELAY_CYC + 1);
  pll_seq_state_t state, nxt;
  logic lock_s, timeout, lost, ws_now, ws_nxt;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [GW-1:0] gcnt;
  logic [RW-1:0] retry_nxt;
`ifdef PLL_LOCK_LOSS_RECOVER_EN
  localparam pll_seq_state_t LOSS_ST = RST_HOLD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lost_cnt <= '0;
    else if (lost && !restart) lost_cnt <= lost_cnt + 8'(lost_cnt != 8'hff);
`else
  localparam pll_seq_state_t LOSS_ST = FAIL;
`endif
  pll_seq_sync2 #(.W(1)) u_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));
  assign state_o = state;
  assign ws_now = state == WAIT_LOCK || state == STABLE;
  assign ws_nxt = nxt == WAIT_LOCK || nxt == STABLE;
  always_comb begin
    nxt = state;
    retry_nxt = retry_cnt;
    lost = 1'b0;
    timeout = tcnt == TW'(LOCK_TIMEOUT_CYC - 1);
    case (state)
      RST_HOLD: nxt = hcnt == HW'(RST_HOLD_CYC - 1) ? WAIT_LOCK : RST_HOLD;
      WAIT_LOCK, STABLE:
        if (timeout) begin
          nxt = retry_cnt == RW'(MAX_RETRY) ? FAIL : RST_HOLD;
          retry_nxt = retry_cnt + RW'(retry_cnt != RW'(MAX_RETRY));
        end
        else if (!lock_s) nxt = WAIT_LOCK;
        else nxt = state == WAIT_LOCK ? STABLE : scnt == SW'(LOCK_STABLE_CYC - 1) ? GATE_DLY : STABLE;
      GATE_DLY, RUN: begin
        lost = !lock_s;
        nxt = lost ? LOSS_ST : state == RUN || gcnt == GW'(GATE_DELAY_CYC - 1) ? RUN : GATE_DLY;
      end
      default: nxt = FAIL;
    endcase
    if (restart || (lost && LOSS_ST == RST_HOLD)) retry_nxt = '0;
    if (restart) nxt = RST_HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= RST_HOLD;
      retry_cnt    <= '0;
      hcnt         <= '0;
      tcnt         <= '0;
      scnt         <= '0;
      gcnt         <= '0;
      pll_rst      <= 1'b1;
      clkout0_gate <= 1'b0;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= nxt;
      retry_cnt    <= retry_nxt;
      hcnt         <= state == RST_HOLD && nxt == RST_HOLD && !restart ? hcnt + HW'(hcnt != HW'(RST_HOLD_CYC)) : '0;
      tcnt         <= ws_now && ws_nxt ? tcnt + TW'(tcnt != TW'(LOCK_TIMEOUT_CYC)) : '0;
      scnt         <= state == STABLE && nxt == STABLE ? scnt + SW'(scnt != SW'(LOCK_STABLE_CYC)) : '0;
      gcnt         <= state == GATE_DLY && nxt == GATE_DLY ? gcnt + GW'(gcnt != GW'(GATE_DELAY_CYC)) : '0;
      pll_rst      <= nxt == RST_HOLD || nxt == FAIL;
      clkout0_gate <= nxt == RUN;
      ready        <= nxt == RUN;
      fail         <= nxt == FAIL;
    end
endmodule
